// File: rtl/show_capture.sv
// show_capture: rebuilds per-digit segment registers from a scanned 7-segment bus and checks scan order.
// Optional SHOW_CAPTURE_HEX_EN adds a registered per-digit hex decoder (digits_hex/digits_ok).
module show_capture #(
  parameter int unsigned NUM_DIGITS = 7
) (
  input  logic                      low_h,
  input  logic                      rst,
  input  logic [7:0]                led,
  input  logic [6:0]                content,
  output logic [7*NUM_DIGITS-1:0]   digits_seg,
  output logic [4*NUM_DIGITS-1:0]   digits_hex,
  output logic [NUM_DIGITS-1:0]     digits_ok,
  output logic                      locked,
  output logic                      frame_done,
  output logic                      seq_err
);
  typedef enum logic {SYNC, RUN} state_t;
  localparam logic [2:0] FIRST = (NUM_DIGITS == 1) ? 3'd0 : 3'd1;
  localparam logic [2:0] LAST  = 3'(NUM_DIGITS - 1);
  state_t     state_q, state_d;
  logic [7:0] led_q;
  logic [6:0] content_q;
  logic [2:0] exp_q, exp_d, idx;
  logic       idle, is_dig, store, fd_d, se_d, frame_done_q, seq_err_q;
  logic [6:0] seg_q [NUM_DIGITS];
  always_comb begin
    idle   = led_q == 8'hFF;
    is_dig = 1'b0;
    idx    = 3'd0;
    for (int k = 0; k < 8; k++)
      if (k < int'(NUM_DIGITS) && led_q == ~(8'b1 << k)) begin
        is_dig = 1'b1;
        idx    = 3'(k);
      end
  end
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    store   = 1'b0;
    fd_d    = 1'b0;
    se_d    = 1'b0;
    if (!idle && !is_dig) begin
      se_d    = 1'b1;
      state_d = SYNC;
    end else if (is_dig && state_q == SYNC) begin
      if (idx == 3'd0) begin
        store   = 1'b1;
        state_d = RUN;
        exp_d   = FIRST;
        fd_d    = NUM_DIGITS == 1;
      end
    end else if (is_dig && idx == exp_q) begin
      store = 1'b1;
      fd_d  = idx == LAST;
      exp_d = (idx == LAST) ? 3'd0 : exp_q + 3'd1;
    end else if (is_dig) begin
      // out-of-order digit 0 is taken as the start of a fresh frame
      se_d = 1'b1;
      if (idx == 3'd0) begin
        store = 1'b1;
        exp_d = FIRST;
      end else state_d = SYNC;
    end
  end
`ifdef SHOW_CAPTURE_HEX_EN
  logic [3:0] hex_q [NUM_DIGITS];
  logic       ok_q  [NUM_DIGITS];
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h10; 7'h79: decode = 5'h11; 7'h24: decode = 5'h12; 7'h30: decode = 5'h13;
      7'h19: decode = 5'h14; 7'h12: decode = 5'h15; 7'h02: decode = 5'h16; 7'h78: decode = 5'h17;
      7'h00: decode = 5'h18; 7'h10: decode = 5'h19; 7'h08: decode = 5'h1A; 7'h03: decode = 5'h1B;
      7'h46: decode = 5'h1C; 7'h21: decode = 5'h1D; 7'h06: decode = 5'h1E; 7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction
`endif
  always_ff @(posedge low_h) begin
    if (rst) begin
      led_q        <= 8'hFF;
      content_q    <= 7'h7F;
      state_q      <= SYNC;
      exp_q        <= 3'd0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        seg_q[k] <= 7'h7F;
`ifdef SHOW_CAPTURE_HEX_EN
        hex_q[k] <= 4'h0;
        ok_q[k]  <= 1'b0;
`endif
      end
    end else begin
      led_q        <= led;
      content_q    <= content;
      state_q      <= state_d;
      exp_q        <= exp_d;
      frame_done_q <= fd_d;
      seq_err_q    <= se_d;
      for (int k = 0; k < int'(NUM_DIGITS); k++)
        if (store && idx == 3'(k)) begin
          seg_q[k] <= content_q;
`ifdef SHOW_CAPTURE_HEX_EN
          {ok_q[k], hex_q[k]} <= decode(content_q);
`endif
        end
    end
  end
  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_out
    assign digits_seg[7*g +: 7] = seg_q[g];
`ifdef SHOW_CAPTURE_HEX_EN
    assign digits_hex[4*g +: 4] = hex_q[g];
    assign digits_ok[g]         = ok_q[g];
`endif
  end
`ifndef SHOW_CAPTURE_HEX_EN
  assign digits_hex = '0;
  assign digits_ok  = '0;
`endif
  assign locked     = state_q == RUN;
  assign frame_done = frame_done_q;
  assign seq_err    = seq_err_q;
endmodule

// File: tb/tb_show_capture.sv
// tb_show_capture: directed and random scan-bus stimulus against a frame-level model of show_capture.
module tb_show_capture;
  localparam int ND = 7;
  localparam logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic            low_h = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      led = 8'hFF;
  logic [6:0]      content = 7'h7F;
  logic [7*ND-1:0] digits_seg;
  logic [4*ND-1:0] digits_hex;
  logic [ND-1:0]   digits_ok;
  logic            locked, frame_done, seq_err;
  int vecs = 0;
  int errs = 0;
  logic [6:0] m_seg [ND];
  bit         m_run, m_fd, m_se;
  int         m_exp;
  logic [7:0] pl = 8'hFF;
  logic [6:0] pc = 7'h7F;

  show_capture #(.NUM_DIGITS(ND)) dut (
    .low_h(low_h), .rst(rst), .led(led), .content(content),
    .digits_seg(digits_seg), .digits_hex(digits_hex), .digits_ok(digits_ok),
    .locked(locked), .frame_done(frame_done), .seq_err(seq_err)
  );

  always #5 low_h = ~low_h;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] hexof(input logic [6:0] s);
    for (int v = 0; v < 16; v++) if (GL[v] == s) return {1'b1, 4'(v)};
    return 5'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_seg[i] = 7'h7F;
    m_run = 0; m_exp = 0; m_fd = 0; m_se = 0;
  endtask

  // frame rules: digits must arrive 0,1,..,ND-1 while locked; idle bus is a pause
  task automatic model_apply(input logic [7:0] l, input logic [6:0] c);
    int z, p;
    m_fd = 0; m_se = 0;
    if (l == 8'hFF) return;
    z = 0; p = 0;
    for (int i = 0; i < 8; i++) if (!l[i]) begin z++; p = i; end
    if (z != 1 || p >= ND) begin m_se = 1; m_run = 0; return; end
    if (!m_run) begin
      if (p == 0) begin m_seg[0] = c; m_run = 1; m_exp = 1 % ND; m_fd = ND == 1; end
      return;
    end
    if (p == m_exp) begin
      m_seg[p] = c; m_fd = p == ND - 1; m_exp = (p + 1) % ND;
      return;
    end
    m_se = 1;
    if (p == 0) begin m_seg[0] = c; m_exp = 1 % ND; end
    else m_run = 0;
  endtask

  task automatic compare_all();
    logic [63:0] es, eh, eo;
    logic [4:0]  d;
    es = '0; eh = '0; eo = '0;
    for (int i = 0; i < ND; i++) begin
      es[7*i +: 7] = m_seg[i];
`ifdef SHOW_CAPTURE_HEX_EN
      d = hexof(m_seg[i]);
`else
      d = 5'h0;
`endif
      eh[4*i +: 4] = d[3:0];
      eo[i] = d[4];
    end
    chk("seg", 64'(digits_seg), es);
    chk("hex", 64'(digits_hex), eh);
    chk("ok", 64'(digits_ok), eo);
    chk("locked", 64'(locked), 64'(m_run));
    chk("frame_done", 64'(frame_done), 64'(m_fd));
    chk("seq_err", 64'(seq_err), 64'(m_se));
  endtask

  task automatic step(input logic [7:0] l, input logic [6:0] c, input logic r);
    @(negedge low_h);
    led = l; content = c; rst = r;
    @(posedge low_h);
    #1;
    if (r) begin
      model_reset();
      pl = 8'hFF; pc = 7'h7F;
    end else begin
      model_apply(pl, pc);
      pl = l; pc = c;
    end
    compare_all();
  endtask

  function automatic logic [7:0] dsel(input int i);
    return ~(8'b1 << i);
  endfunction

  initial begin
    int sc, r;
    step(8'hFF, 7'h7F, 1'b1);
    chk("rst_seg", 64'(digits_seg), 64'({ND{7'h7F}}));
    chk("rst_locked", 64'(locked), 64'd0);
    // in-order scan of glyphs 0..6
    for (int i = 0; i < ND; i++) step(dsel(i), GL[i], 1'b0);
    step(8'hFF, 7'h7F, 1'b0);
    chk("t1_frame", 64'(frame_done), 64'd1);
    chk("t1_seg", 64'(digits_seg), 64'({7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}));
    chk("t1_locked", 64'(locked), 64'd1);
    // out-of-order digit then resync on digit 0
    step(dsel(0), GL[8], 1'b0);
    step(dsel(1), GL[9], 1'b0);
    step(dsel(3), GL[10], 1'b0);
    step(dsel(0), GL[11], 1'b0);
    chk("t2_err", 64'(seq_err), 64'd1);
    chk("t2_unlock", 64'(locked), 64'd0);
    step(8'hFF, 7'h7F, 1'b0);
    chk("t2_relock", 64'(locked), 64'd1);
    // illegal selects
    step(8'b11110011, 7'h00, 1'b0);
    step(8'h7F, 7'h00, 1'b0);
    chk("t3_two_low", 64'(seq_err), 64'd1);
    step(8'hFF, 7'h7F, 1'b0);
    chk("t3_bit7", 64'(seq_err), 64'd1);
    // pause between digits 2 and 3
    for (int i = 0; i < 3; i++) step(dsel(i), GL[15 - i], 1'b0);
    for (int i = 0; i < 5; i++) step(8'hFF, 7'h7F, 1'b0);
    for (int i = 3; i < ND; i++) step(dsel(i), GL[15 - i], 1'b0);
    step(8'hFF, 7'h7F, 1'b0);
    chk("t4_frame", 64'(frame_done), 64'd1);
    // hex glyphs A..F and blank
    for (int i = 0; i < 6; i++) step(dsel(i), GL[10 + i], 1'b0);
    step(dsel(6), 7'h7F, 1'b0);
    step(8'hFF, 7'h7F, 1'b0);
`ifdef SHOW_CAPTURE_HEX_EN
    chk("t5_hex", 64'(digits_hex), 64'h0FEDCBA);
    chk("t5_ok", 64'(digits_ok), 64'b0111111);
`endif
    // reset mid-frame, following digit 4 is ignored silently
    for (int i = 0; i < 4; i++) step(dsel(i), GL[i], 1'b0);
    step(8'hFF, 7'h7F, 1'b1);
    chk("t6_seg", 64'(digits_seg), 64'({ND{7'h7F}}));
    step(dsel(4), GL[4], 1'b0);
    step(8'hFF, 7'h7F, 1'b0);
    step(8'hFF, 7'h7F, 1'b0);
    chk("t6_no_err", 64'(seq_err), 64'd0);
    chk("t6_sync", 64'(locked), 64'd0);
    // random traffic, mostly in-order scanning
    sc = 0;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 13) begin
        step(dsel(sc), ($urandom_range(0, 1) != 0) ? GL[$urandom_range(0, 15)] : 7'($urandom), 1'b0);
        sc = (sc + 1) % ND;
      end else if (r < 16) step(8'hFF, 7'($urandom), 1'b0);
      else if (r == 16) step(dsel(int'($urandom_range(0, ND - 1))), 7'($urandom), 1'b0);
      else if (r == 17) step(8'($urandom), 7'($urandom), 1'b0);
      else if (r == 18) begin
        step(dsel(0), GL[$urandom_range(0, 15)], 1'b0);
        sc = 1 % ND;
      end else step(8'hFF, 7'h7F, $urandom_range(0, 3) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
